// File: rtl/trace_capture.sv
// On-chip trace buffer: circular pre-trigger history, programmable post-trigger window,
// then an oldest-first dump of the captured window over a valid/ready stream.
module trace_capture #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 256,
    localparam int AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              arm,
    input  logic              trig,
    input  logic [DWIDTH-1:0] probe,
    input  logic [AWIDTH-1:0] post_count,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last
);

    typedef enum logic [1:0] {IDLE, ARMED, POST, DUMP} state_t;

    localparam logic [AWIDTH-1:0] A_ONE = AWIDTH'(1);
    localparam logic [AWIDTH:0]   F_ONE = (AWIDTH+1)'(1);
    localparam logic [AWIDTH:0]   FULL  = (AWIDTH+1)'(DEPTH);

    state_t              state_reg, state_next;
    logic [AWIDTH-1:0]   wptr_reg, wptr_next, wptr_inc;
    logic [AWIDTH:0]     fill_reg, fill_next, fill_inc;
    logic [AWIDTH-1:0]   post_reg, post_next;
    logic [AWIDTH-1:0]   remain_reg, remain_next;
    logic [AWIDTH-1:0]   rd_addr_reg, rd_addr_next;
    logic [AWIDTH:0]     rd_left_reg, rd_left_next;
    logic                out_valid_reg, out_valid_next;
    logic                out_last_reg, out_last_next;
    logic                done_reg, done_next;
    logic                we, rd_en;

    logic [DWIDTH-1:0]   mem [DEPTH];
    logic [DWIDTH-1:0]   rd_data_reg;

    always_ff @(posedge clk) begin
        if (we) mem[wptr_reg] <= probe;
    end

    // Read data only advances on a read request, so it doubles as the stall-stable output register.
    always_ff @(posedge clk) begin
        if (!xrst)      rd_data_reg <= '0;
        else if (rd_en) rd_data_reg <= mem[rd_addr_reg];
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            state_reg     <= IDLE;
            wptr_reg      <= '0;
            fill_reg      <= '0;
            post_reg      <= '0;
            remain_reg    <= '0;
            rd_addr_reg   <= '0;
            rd_left_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wptr_reg      <= wptr_next;
            fill_reg      <= fill_next;
            post_reg      <= post_next;
            remain_reg    <= remain_next;
            rd_addr_reg   <= rd_addr_next;
            rd_left_reg   <= rd_left_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wptr_next      = wptr_reg;
        fill_next      = fill_reg;
        post_next      = post_reg;
        remain_next    = remain_reg;
        rd_addr_next   = rd_addr_reg;
        rd_left_next   = rd_left_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;
        done_next      = 1'b0;
        we             = 1'b0;
        rd_en          = 1'b0;
        wptr_inc       = wptr_reg + A_ONE;
        fill_inc       = (fill_reg == FULL) ? fill_reg : fill_reg + F_ONE;

        case (state_reg)
            IDLE: begin
                if (arm) begin
                    state_next = ARMED;
                    wptr_next  = '0;
                    fill_next  = '0;
                    post_next  = post_count;
                end
            end
            ARMED, POST: begin
                we        = 1'b1;
                wptr_next = wptr_inc;
                fill_next = fill_inc;
                // Window start tracks every write so it is ready when the final write lands.
                rd_addr_next = wptr_inc - fill_inc[AWIDTH-1:0];
                rd_left_next = fill_inc;
                if (state_reg == ARMED) begin
                    if (trig) begin
                        if (post_reg == '0) begin
                            state_next = DUMP;
                        end else begin
                            state_next  = POST;
                            remain_next = post_reg;
                        end
                    end
                end else begin
                    remain_next = remain_reg - A_ONE;
                    if (remain_reg == A_ONE) state_next = DUMP;
                end
            end
            DUMP: begin
                if (!out_valid_reg || out_ready) begin
                    if (out_valid_reg && out_last_reg) begin
                        out_valid_next = 1'b0;
                        out_last_next  = 1'b0;
                        done_next      = 1'b1;
                        state_next     = IDLE;
                    end else begin
                        rd_en          = 1'b1;
                        rd_addr_next   = rd_addr_reg + A_ONE;
                        rd_left_next   = rd_left_reg - F_ONE;
                        out_valid_next = 1'b1;
                        out_last_next  = (rd_left_reg == F_ONE);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign out_data  = rd_data_reg;

endmodule
